// File: rtl/vertex_viewport_mapper.sv
// Perspective divide and viewport mapping of clip-space vertices to integer screen pixels.
// A single restoring divider produces one quotient bit per cycle, first for x, then for y.
module vertex_viewport_mapper #(
  parameter int M         = 11,
  parameter int SCREEN_W  = 640,
  parameter int SCREEN_H  = 480,
  localparam int XW       = $clog2(SCREEN_W),
  localparam int YW       = $clog2(SCREEN_H),
  localparam int NUMW     = M + $clog2((SCREEN_W > SCREEN_H) ? SCREEN_W : SCREEN_H)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [M-1:0]  in_x,
  input  logic [M-1:0]  in_y,
  input  logic [M-1:0]  in_z,
  input  logic [M-1:0]  in_w,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [XW-1:0] out_sx,
  output logic [YW-1:0] out_sy,
  output logic [M-1:0]  out_z,
  output logic          out_clip,
  output logic          out_offscr
);

  localparam int CW = $clog2(NUMW);
  localparam logic [CW-1:0]          LAST   = CW'(NUMW - 1);
  localparam logic signed [NUMW-1:0] HW_N   = NUMW'(SCREEN_W / 2);
  localparam logic signed [NUMW-1:0] HH_N   = NUMW'(SCREEN_H / 2);
  localparam logic signed [NUMW:0]   HW_F   = (NUMW + 1)'(SCREEN_W / 2);
  localparam logic signed [NUMW:0]   HH_F   = (NUMW + 1)'(SCREEN_H / 2);
  localparam logic signed [NUMW:0]   XMAX_F = (NUMW + 1)'(SCREEN_W - 1);
  localparam logic signed [NUMW:0]   YMAX_F = (NUMW + 1)'(SCREEN_H - 1);
  localparam logic [XW-1:0]          XMAX   = XW'(SCREEN_W - 1);
  localparam logic [YW-1:0]          YMAX   = YW'(SCREEN_H - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    DIV_X = 3'd1,
    DIV_Y = 3'd2,
    FIX   = 3'd3,
    OUT   = 3'd4
  } state_t;

  state_t state_r, state_s;

  logic            in_ready_r, out_valid_r;
  logic            x_neg_r;
  logic [M-1:0]    y_r, w_r;
  logic [CW-1:0]   cnt_r;
  logic [NUMW:0]   rem_r;
  logic [NUMW-1:0] quo_r, qx_r;
  logic [XW-1:0]   out_sx_r;
  logic [YW-1:0]   out_sy_r;
  logic [M-1:0]    out_z_r;
  logic            out_clip_r, out_offscr_r;

  logic                   accept_s, w_pos_s;
  logic signed [NUMW-1:0] nx_s, ny_s;
  logic [NUMW-1:0]        nx_abs_s, ny_abs_s;
  logic [NUMW+1:0]        shift_s, dvs_s;
  logic [NUMW:0]          rem_n_s;
  logic [NUMW-1:0]        quo_n_s;
  logic signed [NUMW:0]   qx_s, qy_s, rx_s, ry_s;
  logic [XW-1:0]          sx_s;
  logic [YW-1:0]          sy_s;
  logic                   sat_s;

  // Numerators, divider step and the sign/offset/clamp arithmetic of the fix-up cycle.
  always_comb begin
    accept_s = in_valid && in_ready_r;
    w_pos_s  = !in_w[M-1] && (in_w != {M{1'b0}});
    nx_s     = $signed({{(NUMW - M){in_x[M-1]}}, in_x}) * HW_N;
    ny_s     = $signed({{(NUMW - M){y_r[M-1]}}, y_r}) * HH_N;
    nx_abs_s = nx_s[NUMW-1] ? -nx_s : nx_s;
    ny_abs_s = ny_s[NUMW-1] ? -ny_s : ny_s;

    shift_s = {rem_r, quo_r[NUMW-1]};
    dvs_s   = {{(NUMW + 2 - M){1'b0}}, w_r};
    if (shift_s >= dvs_s) begin
      rem_n_s = (NUMW + 1)'(shift_s - dvs_s);
      quo_n_s = {quo_r[NUMW-2:0], 1'b1};
    end else begin
      rem_n_s = shift_s[NUMW:0];
      quo_n_s = {quo_r[NUMW-2:0], 1'b0};
    end

    // Quotients are magnitudes; re-applying the sign gives truncation toward zero.
    qx_s = x_neg_r  ? -$signed({1'b0, qx_r})  : $signed({1'b0, qx_r});
    qy_s = y_r[M-1] ? -$signed({1'b0, quo_r}) : $signed({1'b0, quo_r});
    rx_s = HW_F + qx_s;
    ry_s = HH_F - qy_s;

    sat_s = 1'b0;
    if (rx_s[NUMW]) begin
      sx_s  = {XW{1'b0}};
      sat_s = 1'b1;
    end else if (rx_s > XMAX_F) begin
      sx_s  = XMAX;
      sat_s = 1'b1;
    end else begin
      sx_s = rx_s[XW-1:0];
    end
    if (ry_s[NUMW]) begin
      sy_s  = {YW{1'b0}};
      sat_s = 1'b1;
    end else if (ry_s > YMAX_F) begin
      sy_s  = YMAX;
      sat_s = 1'b1;
    end else begin
      sy_s = ry_s[YW-1:0];
    end
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_s = w_pos_s ? DIV_X : OUT;
        end else begin
          state_s = IDLE;
        end
      end
      DIV_X: state_s = (cnt_r == LAST) ? DIV_Y : DIV_X;
      DIV_Y: state_s = (cnt_r == LAST) ? FIX : DIV_Y;
      FIX:   state_s = OUT;
      OUT: begin
        if (out_ready) begin
          state_s = IDLE;
        end else begin
          state_s = OUT;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // State register, handshake flags, divider datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      in_ready_r   <= 1'b0;
      out_valid_r  <= 1'b0;
      x_neg_r      <= 1'b0;
      y_r          <= {M{1'b0}};
      w_r          <= {M{1'b0}};
      cnt_r        <= {CW{1'b0}};
      rem_r        <= {(NUMW + 1){1'b0}};
      quo_r        <= {NUMW{1'b0}};
      qx_r         <= {NUMW{1'b0}};
      out_sx_r     <= {XW{1'b0}};
      out_sy_r     <= {YW{1'b0}};
      out_z_r      <= {M{1'b0}};
      out_clip_r   <= 1'b0;
      out_offscr_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      in_ready_r  <= (state_s == IDLE);
      out_valid_r <= (state_s == OUT);
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            x_neg_r <= in_x[M-1];
            y_r     <= in_y;
            w_r     <= in_w;
            out_z_r <= in_z;
            cnt_r   <= {CW{1'b0}};
            rem_r   <= {(NUMW + 1){1'b0}};
            quo_r   <= nx_abs_s;
            if (!w_pos_s) begin
              out_sx_r     <= {XW{1'b0}};
              out_sy_r     <= {YW{1'b0}};
              out_clip_r   <= 1'b1;
              out_offscr_r <= 1'b0;
            end
          end
        end
        DIV_X: begin
          if (cnt_r == LAST) begin
            cnt_r <= {CW{1'b0}};
            qx_r  <= quo_n_s;
            rem_r <= {(NUMW + 1){1'b0}};
            quo_r <= ny_abs_s;
          end else begin
            cnt_r <= cnt_r + 1'b1;
            rem_r <= rem_n_s;
            quo_r <= quo_n_s;
          end
        end
        DIV_Y: begin
          cnt_r <= (cnt_r == LAST) ? {CW{1'b0}} : cnt_r + 1'b1;
          rem_r <= rem_n_s;
          quo_r <= quo_n_s;
        end
        FIX: begin
          out_sx_r     <= sx_s;
          out_sy_r     <= sy_s;
          out_clip_r   <= 1'b0;
          out_offscr_r <= sat_s;
        end
        default: begin
        end
      endcase
    end
  end

  assign in_ready   = in_ready_r;
  assign out_valid  = out_valid_r;
  assign out_sx     = out_sx_r;
  assign out_sy     = out_sy_r;
  assign out_z      = out_z_r;
  assign out_clip   = out_clip_r;
  assign out_offscr = out_offscr_r;

endmodule
